// File: rtl/cpu_pkg.sv
// cpu_pkg: shared opcodes, instruction field positions and the fetch FSM state encoding.
// HALTED exists only when FETCH_HALT_EN is defined.
package cpu_pkg;
    localparam logic [3:0] OP_LOAD  = 4'd0;
    localparam logic [3:0] OP_STORE = 4'd1;
    localparam logic [3:0] OP_ADD   = 4'd2;
    localparam logic [3:0] OP_LDC   = 4'd3;
    localparam logic [3:0] OP_SUB   = 4'd4;
    localparam logic [3:0] OP_JMP   = 4'd5;
    localparam logic [3:0] OP_HALT  = 4'd15;
    localparam int OP_MSB  = 15;
    localparam int OP_LSB  = 12;
    localparam int REG_MSB = 11;
    localparam int REG_LSB = 8;
    localparam int IMM_MSB = 7;
    localparam int IMM_LSB = 0;
    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_SAMPLE,
        S_PRESENT,
`ifdef FETCH_HALT_EN
        S_WAIT_BR,
        S_HALTED
`else
        S_WAIT_BR
`endif
    } fetch_state_e;
endpackage

// File: rtl/pc_next_calc.sv
// pc_next_calc: next PC, either sequential or JMP-relative (sign-extended offset), wrapping mod 2^ADDR_W.
module pc_next_calc #(
    parameter int ADDR_W = 16
) (
    input  logic [ADDR_W-1:0] pc,
    input  logic [ADDR_W-1:0] instr_pc,
    input  logic [7:0]        offset,
    input  logic              is_branch,
    input  logic              taken,
    output logic [ADDR_W-1:0] next_pc
);
    assign next_pc = (is_branch && taken) ? instr_pc + {{(ADDR_W-8){offset[7]}}, offset}
                                          : pc + {{(ADDR_W-1){1'b0}}, 1'b1};
endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC/fetch sequencer feeding decode over valid/ready, with JMP resolution.
// Define FETCH_HALT_EN to stop fetching on a captured HALT opcode.
module instr_fetch_unit
    import cpu_pkg::*;
#(
    parameter int                ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [ADDR_W-1:0] im_addr,
    output logic              im_rd,
    input  logic [15:0]       im_instr,
    output logic [15:0]       instr,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              instr_valid,
    input  logic              instr_ready,
    input  logic              br_done,
    input  logic              br_taken,
    output logic              halted
);
    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d, instr_pc_q, instr_pc_d, next_pc;
    logic [15:0]       instr_q, instr_d;

    pc_next_calc #(.ADDR_W(ADDR_W)) u_pc_next (
        .pc        (pc_q),
        .instr_pc  (instr_pc_q),
        .offset    (instr_q[IMM_MSB:IMM_LSB]),
        .is_branch (state_q == S_WAIT_BR),
        .taken     (br_taken),
        .next_pc   (next_pc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            pc_q       <= RESET_PC;
            instr_q    <= '0;
            instr_pc_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        case (state_q)
            S_IDLE:   state_d = start ? S_ISSUE : S_IDLE;
            S_ISSUE:  state_d = S_SAMPLE;
            S_SAMPLE: begin
                instr_d    = im_instr;
                instr_pc_d = pc_q;
                state_d    = S_PRESENT;
`ifdef FETCH_HALT_EN
                if (im_instr[OP_MSB:OP_LSB] == OP_HALT) state_d = S_HALTED;
`endif
            end
            S_PRESENT: begin
                if (instr_ready) begin
                    state_d = (instr_q[OP_MSB:OP_LSB] == OP_JMP) ? S_WAIT_BR : S_ISSUE;
                    pc_d    = (instr_q[OP_MSB:OP_LSB] == OP_JMP) ? pc_q : next_pc;
                end
            end
            S_WAIT_BR: begin
                if (br_done) begin
                    pc_d    = next_pc;
                    state_d = S_ISSUE;
                end
            end
            default: state_d = state_q;
        endcase
    end

    // The PC register doubles as the memory address; it only changes once a fetch has been consumed.
    assign im_addr     = pc_q;
    assign im_rd       = (state_q == S_ISSUE);
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign instr_valid = (state_q == S_PRESENT);
`ifdef FETCH_HALT_EN
    assign halted      = (state_q == S_HALTED);
`else
    assign halted      = 1'b0;
`endif
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed checks of fetch timing, JMP resolution, backpressure, reset and HALT.
module tb_instr_fetch_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] im_addr;
    logic        im_rd;
    logic [15:0] im_instr;
    logic [15:0] instr;
    logic [15:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready = 1'b1;
    logic        br_done = 1'b0;
    logic        br_taken = 1'b0;
    logic        halted;
    logic [15:0] mem [0:255];
    logic [15:0] rd_q = '0;
    int          n_cmp = 0;
    int          n_bad = 0;

    instr_fetch_unit dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .im_addr     (im_addr),
        .im_rd       (im_rd),
        .im_instr    (im_instr),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .br_done     (br_done),
        .br_taken    (br_taken),
        .halted      (halted)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (im_rd) rd_q <= mem[im_addr[7:0]];
    assign im_instr = rd_q;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Called with the DUT in ISSUE; returns with the word presented.
    task automatic fetch(input logic [15:0] addr, input logic [15:0] word);
        check("issue_rd", 32'(im_rd), 32'd1);
        check("issue_addr", 32'(im_addr), 32'(addr));
        step;
        check("sample_rd", 32'(im_rd), 32'd0);
        check("sample_valid", 32'(instr_valid), 32'd0);
        check("sample_addr", 32'(im_addr), 32'(addr));
        step;
        check("present_valid", 32'(instr_valid), 32'd1);
        check("present_instr", 32'(instr), 32'(word));
        check("present_pc", 32'(instr_pc), 32'(addr));
        check("present_rd", 32'(im_rd), 32'd0);
    endtask

    // Called with a JMP presented and ready high; returns in ISSUE at the resolved address.
    task automatic jmp_resolve(input logic taken, input logic [15:0] target);
        step;
        for (int i = 0; i < 3; i++) begin
            check("waitbr_rd", 32'(im_rd), 32'd0);
            check("waitbr_valid", 32'(instr_valid), 32'd0);
            step;
        end
        br_done  = 1'b1;
        br_taken = taken;
        step;
        br_done  = 1'b0;
        br_taken = 1'b0;
        check("jmp_target", 32'(im_addr), 32'(target));
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'h2000;
        mem[0]  = 16'h0000;
        mem[1]  = 16'h0101;
        mem[5]  = 16'h5303;
        mem[8]  = 16'h5203;
        mem[9]  = 16'h530A;
        mem[19] = 16'h55FD;
        mem[17] = 16'h5100;
        step;
        check("rst_addr", 32'(im_addr), 32'd0);
        check("rst_rd", 32'(im_rd), 32'd0);
        check("rst_valid", 32'(instr_valid), 32'd0);
        check("rst_instr", 32'(instr), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step;
            check("idle_rd", 32'(im_rd), 32'd0);
            check("idle_valid", 32'(instr_valid), 32'd0);
            check("idle_addr", 32'(im_addr), 32'd0);
        end
        start = 1'b1;
        step;
        start = 1'b0;
        fetch(16'd0, 16'h0000);
        step;
        fetch(16'd1, 16'h0101);
        step;
        // stray br_done and start outside their states must have no effect
        br_done = 1'b1; br_taken = 1'b1; start = 1'b1;
        fetch(16'd2, 16'h2000);
        step;
        fetch(16'd3, 16'h2000);
        step;
        fetch(16'd4, 16'h2000);
        br_done = 1'b0; br_taken = 1'b0; start = 1'b0;
        step;
        fetch(16'd5, 16'h5303);
        jmp_resolve(1'b1, 16'd8);
        fetch(16'd8, 16'h5203);
        jmp_resolve(1'b0, 16'd9);
        fetch(16'd9, 16'h530A);
        jmp_resolve(1'b1, 16'd19);
        fetch(16'd19, 16'h55FD);
        jmp_resolve(1'b1, 16'd16);
        fetch(16'd16, 16'h2000);
        instr_ready = 1'b0;
        for (int i = 0; i < 7; i++) begin
            step;
            check("bp_valid", 32'(instr_valid), 32'd1);
            check("bp_instr", 32'(instr), 32'h2000);
            check("bp_pc", 32'(instr_pc), 32'd16);
            check("bp_rd", 32'(im_rd), 32'd0);
        end
        instr_ready = 1'b1;
        step;
        fetch(16'd17, 16'h5100);
        step;
        step;
        check("waitbr_addr", 32'(im_addr), 32'd17);
        rst = 1'b1;
        #1;
        check("midrst_addr", 32'(im_addr), 32'd0);
        check("midrst_rd", 32'(im_rd), 32'd0);
        check("midrst_valid", 32'(instr_valid), 32'd0);
        check("midrst_instr", 32'(instr), 32'd0);
        check("midrst_pc", 32'(instr_pc), 32'd0);
        step;
        rst = 1'b0;
        mem[2] = 16'hF000;
        step;
        check("post_rst_rd", 32'(im_rd), 32'd0);
        start = 1'b1;
        step;
        start = 1'b0;
        fetch(16'd0, 16'h0000);
        step;
        fetch(16'd1, 16'h0101);
        step;
        check("halt_issue_rd", 32'(im_rd), 32'd1);
        check("halt_issue_addr", 32'(im_addr), 32'd2);
        step;
        step;
`ifdef FETCH_HALT_EN
        for (int i = 0; i < 5; i++) begin
            check("halt_halted", 32'(halted), 32'd1);
            check("halt_valid", 32'(instr_valid), 32'd0);
            check("halt_rd", 32'(im_rd), 32'd0);
            step;
        end
`else
        check("nohalt_valid", 32'(instr_valid), 32'd1);
        check("nohalt_instr", 32'(instr), 32'hF000);
        check("nohalt_halted", 32'(halted), 32'd0);
        step;
        check("nohalt_next", 32'(im_addr), 32'd3);
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
